// File: rtl/alu_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_arbiter_if : request/response and shared-ALU signals of the arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic [1:0]                 req_valid;
  logic [1:0]                 req_ready;
  logic [1:0][DATA_WIDTH-1:0] req_op1;
  logic [1:0][DATA_WIDTH-1:0] req_op2;
  logic [1:0][2:0]            req_ctrl;
  logic [1:0]                 rsp_valid;
  logic [1:0]                 rsp_ready;
  logic [DATA_WIDTH-1:0]      rsp_data;
  logic                       rsp_branch;
  logic [DATA_WIDTH-1:0]      ALUop1;
  logic [DATA_WIDTH-1:0]      ALUop2;
  logic [2:0]                 ALUctrl;
  logic [DATA_WIDTH-1:0]      ALUout;
  logic                       branch_l;

  // Arbiter side
  modport slave (
    input  req_valid, req_op1, req_op2, req_ctrl, rsp_ready, ALUout, branch_l,
    output req_ready, rsp_valid, rsp_data, rsp_branch, ALUop1, ALUop2, ALUctrl
  );

  // Requesters plus ALU side
  modport master (
    output req_valid, req_op1, req_op2, req_ctrl, rsp_ready, ALUout, branch_l,
    input  req_ready, rsp_valid, rsp_data, rsp_branch, ALUop1, ALUop2, ALUctrl
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter : round-robin sharing of one combinational ALU by two requesters
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_ptr;
  logic                  r_grant;
  logic [DATA_WIDTH-1:0] r_op1;
  logic [DATA_WIDTH-1:0] r_op2;
  logic [2:0]            r_ctrl;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_branch;

  logic                  w_any;
  logic                  w_idx;
  logic                  w_accept;
  logic                  w_done;
  logic [1:0]            w_req_ready;
  logic [1:0]            w_rsp_valid;

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    w_any    = |bus.req_valid;
    w_idx    = (&bus.req_valid) ? r_ptr : bus.req_valid[1];
    w_accept = (r_state == IDLE) && w_any;
    w_done   = (r_state == RESP) && bus.rsp_ready[r_grant];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any)  w_next = EXEC;
      EXEC:                w_next = RESP;
      RESP:    if (w_done) w_next = IDLE;
      default:             w_next = IDLE;
    endcase
  end

  always_comb begin
    w_req_ready = 2'b00;
    w_rsp_valid = 2'b00;
    if (w_accept)
      w_req_ready[w_idx] = 1'b1;
    if (r_state == RESP)
      w_rsp_valid[r_grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ptr        <= 1'b0;
      r_grant      <= 1'b0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_ctrl       <= 3'b000;
      r_rsp_data   <= '0;
      r_rsp_branch <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_grant <= w_idx;
        r_ptr   <= ~w_idx;
        r_op1   <= bus.req_op1[w_idx];
        r_op2   <= bus.req_op2[w_idx];
        r_ctrl  <= bus.req_ctrl[w_idx];
      end
      if (r_state == EXEC) begin
        r_rsp_data   <= bus.ALUout;
        r_rsp_branch <= bus.branch_l;
      end
    end
  end

  // ALU inputs come straight from the latch so they only move on a new grant.
  assign bus.ALUop1     = r_op1;
  assign bus.ALUop2     = r_op2;
  assign bus.ALUctrl    = r_ctrl;
  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_branch = r_rsp_branch;

endmodule

`default_nettype wire
